// File: rtl/uart_cs_packet_parser.sv
`default_nettype none
// ============================================================================
// Module  : uart_cs_packet_parser
// Brief   : Hunts SYNC/CMD/payload/CHK frames in the UART RX byte stream and
//           updates the CS configuration or delivers a measurement package.
// Revision: 1.0 - initial release
// ============================================================================
module uart_cs_packet_parser #(
  parameter int                 DATA_W      = 8,
  parameter int                 BIT_SHIFT_W = 4,
  parameter int                 ROWS_W      = 8,
  parameter int                 COLS_W      = 8,
  parameter int                 PACKET_LEN  = 64,
  parameter logic [DATA_W-1:0]  SYNC_BYTE   = 8'hA5,
  parameter int                 TIMEOUT     = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   SAD_busy_flag,
  output logic [BIT_SHIFT_W-1:0] bit_shift_parameter,
  output logic [ROWS_W-1:0]      rows,
  output logic [COLS_W-1:0]      columns,
  output logic                   cfg_valid,
  output logic [PACKET_LEN-1:0]  measurement_package,
  output logic                   meas_valid,
  input  logic                   meas_ready,
  output logic                   pkt_error,
  output logic [1:0]             err_code
);

  localparam int NB     = PACKET_LEN / 8;
  localparam int ASM_W  = (PACKET_LEN > 24) ? PACKET_LEN : 24;
  localparam int CNT_W  = $clog2((NB > 3) ? NB : 3) + 1;
  localparam int GAP_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [DATA_W-1:0] c_cmd_cfg   = 8'h01;
  localparam logic [DATA_W-1:0] c_cmd_meas  = 8'h02;
  localparam logic [CNT_W-1:0]  c_last_cfg  = CNT_W'(2);
  localparam logic [CNT_W-1:0]  c_last_meas = CNT_W'(NB - 1);
  localparam logic [GAP_W-1:0]  c_gap_max   = GAP_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHECK   = 3'd3,
    S_HOLD    = 3'd4
  } state_t;

  state_t             r_state, w_state_next;
  logic               r_is_meas;
  logic [DATA_W-1:0]  r_xor;
  logic [CNT_W-1:0]   r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic [ASM_W-1:0]   r_asm;

  logic               w_accept;
  logic               w_in_pkt;
  logic               w_timeout;
  logic               w_err;
  logic [1:0]         w_err_code;
  logic               w_cfg_load;
  logic               w_meas_load;
  logic [CNT_W-1:0]   w_last;

  assign in_ready  = (r_state == S_IDLE) ? ~SAD_busy_flag
                   : (r_state == S_CMD || r_state == S_PAYLOAD || r_state == S_CHECK);
  assign w_accept  = in_valid & in_ready;
  assign w_in_pkt  = (r_state == S_CMD) || (r_state == S_PAYLOAD) || (r_state == S_CHECK);
  assign w_timeout = w_in_pkt && !w_accept && (r_gap == c_gap_max);
  assign w_last    = r_is_meas ? c_last_meas : c_last_cfg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    w_err_code   = 2'd0;
    w_cfg_load   = 1'b0;
    w_meas_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept && in_data == SYNC_BYTE) w_state_next = S_CMD;
      end
      S_CMD: begin
        if (w_accept) begin
          if (in_data == c_cmd_cfg || in_data == c_cmd_meas) begin
            w_state_next = S_PAYLOAD;
          end else begin
            w_err        = 1'b1;
            w_err_code   = 2'd1;
            w_state_next = S_IDLE;
          end
        end
      end
      S_PAYLOAD: begin
        if (w_accept && r_cnt == w_last) w_state_next = S_CHECK;
      end
      S_CHECK: begin
        if (w_accept) begin
          if (in_data == r_xor) begin
            w_meas_load  = r_is_meas;
            w_cfg_load   = ~r_is_meas;
            w_state_next = r_is_meas ? S_HOLD : S_IDLE;
          end else begin
            w_err        = 1'b1;
            w_err_code   = 2'd2;
            w_state_next = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (meas_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
    // A stalled packet overrides whatever the state would otherwise do.
    if (w_timeout) begin
      w_err        = 1'b1;
      w_err_code   = 2'd3;
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_is_meas           <= 1'b0;
      r_xor               <= '0;
      r_cnt               <= '0;
      r_gap               <= '0;
      r_asm               <= '0;
      bit_shift_parameter <= '0;
      rows                <= '0;
      columns             <= '0;
      cfg_valid           <= 1'b0;
      measurement_package <= '0;
      meas_valid          <= 1'b0;
      pkt_error           <= 1'b0;
      err_code            <= 2'd0;
    end else begin
      cfg_valid <= w_cfg_load;
      pkt_error <= w_err;
      if (w_err) err_code <= w_err_code;

      if (w_in_pkt && !w_accept && !w_timeout) r_gap <= r_gap + 1'b1;
      else                                     r_gap <= '0;

      if (r_state == S_CMD && w_accept) begin
        r_is_meas <= (in_data == c_cmd_meas);
        r_xor     <= in_data;
        r_cnt     <= '0;
      end
      // First payload byte ends up as the most significant byte.
      if (r_state == S_PAYLOAD && w_accept) begin
        r_asm <= {r_asm[ASM_W-DATA_W-1:0], in_data};
        r_xor <= r_xor ^ in_data;
        r_cnt <= r_cnt + 1'b1;
      end

      if (w_cfg_load) begin
        bit_shift_parameter <= r_asm[16 +: BIT_SHIFT_W];
        rows                <= r_asm[8 +: ROWS_W];
        columns             <= r_asm[0 +: COLS_W];
      end

      if (w_meas_load) begin
        measurement_package <= r_asm[PACKET_LEN-1:0];
        meas_valid          <= 1'b1;
      end else if (r_state == S_HOLD && meas_ready) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_cs_packet_parser.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_cs_packet_parser
// Brief   : Directed self-checking bench for uart_cs_packet_parser.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_cs_packet_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        SAD_busy_flag = 1'b1;
  logic [3:0]  bit_shift_parameter;
  logic [7:0]  rows;
  logic [7:0]  columns;
  logic        cfg_valid;
  logic [63:0] measurement_package;
  logic        meas_valid;
  logic        meas_ready = 1'b0;
  logic        pkt_error;
  logic [1:0]  err_code;

  int n_cmp = 0;
  int n_err = 0;
  int err_pulses = 0;
  int cfg_pulses = 0;

  uart_cs_packet_parser #(
    .DATA_W(8), .BIT_SHIFT_W(4), .ROWS_W(8), .COLS_W(8),
    .PACKET_LEN(64), .SYNC_BYTE(8'hA5), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .SAD_busy_flag(SAD_busy_flag),
    .bit_shift_parameter(bit_shift_parameter), .rows(rows), .columns(columns),
    .cfg_valid(cfg_valid),
    .measurement_package(measurement_package), .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .pkt_error(pkt_error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pkt_error) err_pulses++;
    if (cfg_valid) cfg_pulses++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check("send_stall", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int cyc;
    int e0;
    #3 rst = 1'b0;
    tick(3);
    check("rst_ready",  {63'd0, in_ready},   64'd0);
    check("rst_cfgv",   {63'd0, cfg_valid},  64'd0);
    check("rst_measv",  {63'd0, meas_valid}, 64'd0);
    check("rst_err",    {63'd0, pkt_error},  64'd0);
    check("rst_code",   {62'd0, err_code},   64'd0);
    check("rst_cfg",    {40'd0, 4'd0, bit_shift_parameter, rows, columns}, 64'd0);
    check("rst_pkg",    measurement_package, 64'd0);
    rst = 1'b1;
    SAD_busy_flag = 1'b0;
    tick(2);

    // Config packet
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
    check("cfg_valid",  {63'd0, cfg_valid}, 64'd1);
    check("cfg_regs",   {44'd0, bit_shift_parameter, rows, columns}, {44'd0, 4'h3, 8'h10, 8'h20});
    tick(1);
    check("cfg_pulse1", {63'd0, cfg_valid}, 64'd0);
    check("cfg_count",  64'(cfg_pulses), 64'd1);
    check("cfg_noerr",  64'(err_pulses), 64'd0);

    // Measurement packet with downstream back-pressure
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    send_byte(8'h0A);
    check("meas_valid", {63'd0, meas_valid}, 64'd1);
    check("meas_pkg",   measurement_package, 64'h0102030405060708);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_state", {61'd0, meas_valid, in_ready, 1'b0}, {61'd0, 1'b1, 1'b0, 1'b0});
      check("hold_pkg",   measurement_package, 64'h0102030405060708);
    end
    meas_ready = 1'b1;
    tick(1);
    meas_ready = 1'b0;
    check("meas_clear", {62'd0, meas_valid, in_ready}, {62'd0, 1'b0, 1'b1});
    check("meas_keep",  measurement_package, 64'h0102030405060708);
    check("meas_cfgk",  {44'd0, bit_shift_parameter, rows, columns}, {44'd0, 4'h3, 8'h10, 8'h20});

    // Bad checksum
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h00);
    check("chk_err",    {62'd0, pkt_error, cfg_valid}, {62'd0, 1'b1, 1'b0});
    check("chk_code",   {62'd0, err_code}, 64'd2);
    check("chk_cfgk",   {44'd0, bit_shift_parameter, rows, columns}, {44'd0, 4'h3, 8'h10, 8'h20});
    tick(1);
    check("chk_pulse",  {63'd0, pkt_error}, 64'd0);

    // Leading garbage then bad CMD
    e0 = err_pulses;
    send_byte(8'h00); send_byte(8'hFF);
    check("garbage",    64'(err_pulses - e0), 64'd0);
    send_byte(8'hA5); send_byte(8'h07);
    check("cmd_err",    {63'd0, pkt_error}, 64'd1);
    check("cmd_code",   {62'd0, err_code}, 64'd1);
    tick(1);
    check("cmd_count",  64'(err_pulses - e0), 64'd1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07);
    send_byte(8'h08); send_byte(8'h09); send_byte(8'h07);
    check("cfg2_regs",  {43'd0, cfg_valid, bit_shift_parameter, rows, columns}, {43'd0, 1'b1, 4'h7, 8'h08, 8'h09});
    check("cfg2_pkgk",  measurement_package, 64'h0102030405060708);

    // Timeout after a partial packet
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h03);
    cyc = 0;
    while (cyc < 40) begin
      tick(1);
      cyc++;
      if (pkt_error) break;
    end
    check("to_cycles",  64'(cyc), 64'd16);
    check("to_code",    {62'd0, err_code}, 64'd3);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h06);
    check("to_cfg",     {43'd0, cfg_valid, bit_shift_parameter, rows, columns}, {43'd0, 1'b1, 4'h4, 8'h05, 8'h06});

    // Busy in IDLE: SYNC must not be consumed
    tick(1);
    SAD_busy_flag = 1'b1;
    in_data = 8'hA5;
    in_valid = 1'b1;
    tick(3);
    check("busy_ready", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    SAD_busy_flag = 1'b0;
    e0 = cfg_pulses;
    send_byte(8'h01); send_byte(8'h0A); send_byte(8'h0B);
    send_byte(8'h0C); send_byte(8'h00);
    tick(1);
    check("busy_nocfg", 64'(cfg_pulses - e0), 64'd0);
    check("busy_cfgk",  {44'd0, bit_shift_parameter, rows, columns}, {44'd0, 4'h4, 8'h05, 8'h06});

    // Busy after a packet has started is ignored
    send_byte(8'hA5);
    SAD_busy_flag = 1'b1;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    send_byte(8'h04); send_byte(8'h04);
    check("busy_mid",   {43'd0, cfg_valid, bit_shift_parameter, rows, columns}, {43'd0, 1'b1, 4'h2, 8'h03, 8'h04});
    SAD_busy_flag = 1'b0;
    tick(1);

    // Reset mid-packet
    e0 = err_pulses;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h01);
    #2 rst = 1'b0;
    #1;
    check("mrst_outs",  {40'd0, cfg_valid, meas_valid, pkt_error, err_code, 3'd0, bit_shift_parameter, rows, columns}, 64'd0);
    check("mrst_pkg",   measurement_package, 64'd0);
    tick(2);
    rst = 1'b1;
    tick(2);
    check("mrst_noerr", 64'(err_pulses - e0), 64'd0);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h01); send_byte(8'h01); send_byte(8'h00);
    check("mrst_idle",  {43'd0, cfg_valid, bit_shift_parameter, rows, columns}, {43'd0, 1'b1, 4'h1, 8'h01, 8'h01});
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_cs_packet_parser.md
Name: uart_cs_packet_parser

Overview:
- Upstream neighbour of the UART package-arrangement stage.
- Consumes the byte stream from the UART RX core over a valid/ready handshake and hunts for framed packets.
- Each packet is checksum-verified; good packets update the CS configuration registers (bit shift, rows, columns) or deliver one full measurement package downstream.
- Bad or stalled packets are dropped with an error pulse.

Parameters:
- DATA_W, 8: UART byte width; fixed at 8.
- BIT_SHIFT_W, 4: width of bit_shift_parameter, ≤ 8.
- ROWS_W, 8: width of rows, ≤ 8.
- COLS_W, 8: width of columns, ≤ 8.
- PACKET_LEN, 64: measurement package width in bits; must be a multiple of 8. NB = PACKET_LEN/8.
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT, 1024: maximum idle cycles between bytes inside a packet.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- in_data  in  DATA_W  byte from the UART RX core
- in_valid  in  1  in_data is valid
- in_ready  out  1  parser accepts a byte this cycle
- SAD_busy_flag  in  1  SAD engine busy; no new packet may start while high
- bit_shift_parameter  out  BIT_SHIFT_W  configured shift
- rows  out  ROWS_W  configured rows
- columns  out  COLS_W  configured columns
- cfg_valid  out  1  one-cycle pulse when configuration is updated
- measurement_package  out  PACKET_LEN  last good measurement
- meas_valid  out  1  measurement available
- meas_ready  in  1  downstream accepts the measurement
- pkt_error  out  1  one-cycle pulse when a packet is dropped
- err_code  out  2  cause of the last drop: 1 = bad CMD, 2 = checksum, 3 = timeout; held until the next error

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs are 0, state = IDLE, all counters and the assembly register are cleared.
  - A reset asserted mid-packet discards the partial packet; no error pulse.
- Byte transfer occurs on any rising edge with in_valid && in_ready.
- Frame format: SYNC, CMD, payload, CHK.
  - CMD 8'h01 = config; payload is 3 bytes: shift, rows, columns. Each byte's low bits are used.
  - CMD 8'h02 = measurement; payload is NB bytes, MSB-first.
  - CHK = XOR of CMD and all payload bytes.
- States:
  - IDLE:
    - in_ready = ~SAD_busy_flag.
    - An accepted byte equal to SYNC_BYTE moves to CMD; any other accepted byte is discarded silently.
  - CMD:
    - in_ready = 1.
    - 01 or 02: latch the command, seed the running XOR with the CMD byte, clear the byte counter, go to PAYLOAD.
    - Any other value: pkt_error pulse, err_code = 1, back to IDLE.
  - PAYLOAD:
    - in_ready = 1.
    - Each accepted byte shifts into the assembly register from the LSB side (first byte ends as MSB), XORs into the checksum, and increments the counter.
    - After 3 (config) or NB (measurement) bytes, go to CHECK.
  - CHECK:
    - in_ready = 1.
    - On byte accept with CHK equal to the running XOR:
      - Config: registers load at that edge; cfg_valid = 1 for the next cycle; go to IDLE.
      - Measurement: measurement_package loads from the assembly register; meas_valid = 1; go to HOLD.
    - On mismatch: pkt_error pulse, err_code = 2, no register change, back to IDLE.
  - HOLD:
    - in_ready = 0, and measurement_package is stable.
    - meas_valid stays 1 until a cycle with meas_ready = 1; then meas_valid = 0 at that edge and the state returns to IDLE.
- Latency: outputs are visible the cycle after the CHK handshake edge.
- Timeout:
  - In CMD, PAYLOAD and CHECK, a gap counter increments each cycle without a byte accept and clears on each accept.
  - When it reaches TIMEOUT - 1: pkt_error pulse, err_code = 3, back to IDLE. The counter is inactive in IDLE and HOLD.
- SAD_busy_flag has no effect once a packet has started (state ≠ IDLE).
- A SYNC_BYTE value inside the payload or CMD field is treated as data; there is no resynchronisation.
- Outputs are held between updates. A config packet never disturbs measurement_package, and vice versa.

Test Plan:
- Config packet: A5 01 03 10 20 32 → cfg_valid pulses once; bit_shift_parameter = 3, rows = 16, columns = 32; pkt_error stays 0.
- Measurement packet (PACKET_LEN = 64): A5 02 01 02 03 04 05 06 07 08 CHK = 02^01^…^08 = 0A.
  - Required: measurement_package = 64'h0102030405060708 and meas_valid = 1.
  - With meas_ready held 0 for 5 cycles, meas_valid and the data hold and in_ready = 0; meas_ready = 1 clears meas_valid.
- Bad checksum: A5 01 03 10 20 00 → pkt_error pulse, err_code = 2, config unchanged.
- Bad CMD and leading garbage: 00 FF A5 07 → one pulse with err_code = 1. Then a valid config packet parses correctly.
- Timeout with TIMEOUT = 16: A5 01 03, then idle for 16 cycles → pkt_error with err_code = 3. The next full config packet is accepted.
- Busy and reset:
  - SAD_busy_flag = 1 in IDLE → in_ready = 0 and no byte is consumed.
  - Asserting rst after A5 02 01 → all outputs 0, state IDLE, no error pulse.
